// File: rtl/rc4_init_pkg.sv
// Shared types for the RC4 memory initializer: FSM states and fill-pattern modes.
package rc4_init_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_IDENT = 2'b00,
        MODE_DESC  = 2'b01,
        MODE_CONST = 2'b10
    } mode_e;

    // The unused encoding 2'b11 falls back to identity.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_DESC;
            2'b10:   return MODE_CONST;
            default: return MODE_IDENT;
        endcase
    endfunction

endpackage

// File: rtl/rc4_init_datagen.sv
// Combinational fill-pattern generator: maps (mode, index, fill value) to write data.
module rc4_init_datagen
    import rc4_init_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  mode_e              mode,
    input  logic [CNT_W-1:0]   i,
    input  logic [DATA_W-1:0]  fill_value,
    output logic [DATA_W-1:0]  data
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    always_comb begin
        data = DATA_W'(i);
        case (mode)
            MODE_DESC:  data = DATA_W'(LAST - i);
            MODE_CONST: data = fill_value;
            default:    data = DATA_W'(i);
        endcase
    end

endmodule

// File: rtl/rc4_mem_init.sv
// Memory initializer: fills DEPTH words of a shared single-port RAM with a
// selectable pattern, stalling on grant and pulsing done after the last write.
module rc4_mem_init
    import rc4_init_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              grant,
    input  logic              abort,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    output logic              busy,
    output logic              done
);

    localparam int               CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

    state_e              state, state_d;
    logic [CNT_W-1:0]    i, i_d;
    mode_e               mode_q, mode_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [DATA_W-1:0]   data_d;

    always_comb begin
        state_d = state;
        i_d     = i;
        mode_d  = mode_q;
        fill_d  = fill_q;
        wren    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = WRITE;
                    i_d     = '0;
                    mode_d  = decode_mode(mode);
                    fill_d  = fill_value;
                end
            end
            WRITE: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (grant) begin
                    wren = 1'b1;
                    if (i == LAST) state_d = DONE;
                    else           i_d     = i + 1'b1;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Data is generated from the next-cycle index so the registered output
    // lines up with the address of the cycle in which wren is asserted.
    rc4_init_datagen #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_datagen (
        .mode       (mode_d),
        .i          (i_d),
        .fill_value (fill_d),
        .data       (data_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            i      <= '0;
            mode_q <= MODE_IDENT;
            fill_q <= '0;
            data   <= '0;
        end else begin
            state  <= state_d;
            i      <= i_d;
            mode_q <= mode_d;
            fill_q <= fill_d;
            data   <= data_d;
        end
    end

    assign address = ADDR_W'(i);

endmodule

// File: tb/tb_rc4_mem_init.sv
// Self-checking bench for rc4_mem_init: a write-count model plus directed fills.
module tb_rc4_mem_init;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       st[2], gr[2], ab[2];
    logic [1:0] md[2];
    logic [7:0] fv[2];
    logic [7:0] addr_o[2], data_o[2];
    logic       wren_o[2], busy_o[2], done_o[2];

    int n_assert = 0;
    int n_fail   = 0;

    rc4_mem_init #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(st[0]), .mode(md[0]),
        .fill_value(fv[0]), .grant(gr[0]), .abort(ab[0]),
        .address(addr_o[0]), .data(data_o[0]), .wren(wren_o[0]),
        .busy(busy_o[0]), .done(done_o[0]));

    rc4_mem_init #(.ADDR_W(8), .DATA_W(8), .DEPTH(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(st[1]), .mode(md[1]),
        .fill_value(fv[1]), .grant(gr[1]), .abort(ab[1]),
        .address(addr_o[1]), .data(data_o[1]), .wren(wren_o[1]),
        .busy(busy_o[1]), .done(done_o[1]));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a fill is "writes remaining" plus the index of the next write.
    int m_left[2], m_k[2], m_mode[2], m_fill[2];
    bit m_done[2];

    function automatic int dep(input int d);
        return (d == 0) ? 256 : 16;
    endfunction

    function automatic int exp_data(input int d);
        case (m_mode[d])
            1:       return (dep(d) - 1 - m_k[d]) % 256;
            2:       return m_fill[d];
            default: return m_k[d] % 256;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                m_left[d] <= 0;
                m_done[d] <= 1'b0;
                m_k[d]    <= 0;
            end else if (m_done[d]) begin
                m_done[d] <= 1'b0;
            end else if (m_left[d] > 0) begin
                if (ab[d]) begin
                    m_left[d] <= 0;
                end else if (gr[d]) begin
                    m_left[d] <= m_left[d] - 1;
                    m_done[d] <= (m_left[d] == 1);
                    if (m_left[d] > 1) m_k[d] <= m_k[d] + 1;
                end
            end else if (st[d]) begin
                m_left[d] <= dep(d);
                m_k[d]    <= 0;
                m_mode[d] <= int'(md[d]);
                m_fill[d] <= int'(fv[d]);
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                chk($sformatf("d%0d_rst_wren", d), int'(wren_o[d]), 0);
                chk($sformatf("d%0d_rst_busy", d), int'(busy_o[d]), 0);
                chk($sformatf("d%0d_rst_done", d), int'(done_o[d]), 0);
                chk($sformatf("d%0d_rst_addr", d), int'(addr_o[d]), 0);
                chk($sformatf("d%0d_rst_data", d), int'(data_o[d]), 0);
            end else begin
                automatic int ew = (m_left[d] > 0 && gr[d] && !ab[d]) ? 1 : 0;
                chk($sformatf("d%0d_wren", d), int'(wren_o[d]), ew);
                chk($sformatf("d%0d_busy", d), int'(busy_o[d]), (m_left[d] > 0 || m_done[d]) ? 1 : 0);
                chk($sformatf("d%0d_done", d), int'(done_o[d]), int'(m_done[d]));
                if (ew == 1) begin
                    chk($sformatf("d%0d_addr", d), int'(addr_o[d]), m_k[d] % 256);
                    chk($sformatf("d%0d_data", d), int'(data_o[d]), exp_data(d));
                end
            end
        end
    end

    int r_nwr, r_done_c, r_stalls, r_busy_after, r_first_data, r_last_data;
    int r_bad_const, r_first_addr, r_probe_addr, r_probe_data, r_rst_or;
    int r_wad_c, r_wad_addr;

    // Cycle c=1 is the first cycle after the start-accepting edge.
    task automatic run_fill(input int d, input int gmode, input int max_c,
                            input int chg_c, input int abort_c, input int reset_c,
                            input bit hold, input int probe_c);
        r_nwr = 0; r_done_c = 0; r_stalls = 0; r_busy_after = -1;
        r_first_data = -1; r_last_data = -1; r_bad_const = 0; r_first_addr = -1;
        r_probe_addr = -1; r_probe_data = -1; r_rst_or = -1; r_wad_c = 0; r_wad_addr = -1;
        for (int c = 1; c <= max_c; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            gr[d] = (gmode == 0) ? 1'b1 : ((c % 3) == 1);
            ab[d] = (c == abort_c);
            if (c == chg_c) begin
                fv[d] = 8'h00;
                md[d] = 2'b00;
            end
            if (c == reset_c) reset_n = 1'b0;
            if (c == reset_c + 2) reset_n = 1'b1;
            if (hold && r_done_c != 0 && c == r_done_c + 2) st[d] = 1'b0;
            @(negedge clk);
            if (wren_o[d]) begin
                r_nwr++;
                if (r_first_data < 0) begin
                    r_first_data = int'(data_o[d]);
                    r_first_addr = int'(addr_o[d]);
                end
                r_last_data = int'(data_o[d]);
                if (data_o[d] != 8'hA5) r_bad_const++;
                if (r_done_c != 0 && r_wad_c == 0) begin
                    r_wad_c    = c;
                    r_wad_addr = int'(addr_o[d]);
                end
            end
            if (busy_o[d] && !done_o[d] && !gr[d]) r_stalls++;
            if (done_o[d] && r_done_c == 0) r_done_c = c;
            if (c == probe_c) begin
                r_probe_addr = int'(addr_o[d]);
                r_probe_data = int'(data_o[d]);
            end
            if (c == reset_c)
                r_rst_or = int'(wren_o[d] | busy_o[d] | done_o[d] | (|addr_o[d]) | (|data_o[d]));
            if (r_done_c != 0 && c == r_done_c + 1) r_busy_after = int'(busy_o[d]);
            if (r_done_c != 0 && c >= r_done_c + (hold ? 2 : 1)) break;
        end
        ab[d] = 1'b0;
    endtask

    task automatic kick(input int d, input logic [1:0] m, input logic [7:0] f, input bit keep);
        md[d] = m;
        fv[d] = f;
        st[d] = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) st[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; gr[d] = 1'b0; ab[d] = 1'b0; md[d] = 2'b00; fv[d] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy_a", int'(busy_o[0]), 0);
        chk("reset_addr_a", int'(addr_o[0]), 0);
        chk("reset_done_b", int'(done_o[1]), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Identity, full depth, grant held high
        kick(0, 2'b00, 8'h00, 1'b0);
        run_fill(0, 0, 300, 0, 0, 0, 1'b0, 101);
        chk("ident_nwr", r_nwr, 256);
        chk("ident_done_c", r_done_c, 257);
        chk("ident_busy_after", r_busy_after, 0);
        chk("ident_first_addr", r_first_addr, 0);
        chk("ident_first_data", r_first_data, 0);
        chk("ident_last_data", r_last_data, 255);
        chk("ident_probe_addr", r_probe_addr, 100);
        chk("ident_probe_data", r_probe_data, 100);

        // Descending on the 16-deep instance
        @(posedge clk); #1;
        kick(1, 2'b01, 8'h00, 1'b0);
        run_fill(1, 0, 40, 0, 0, 0, 1'b0, 0);
        chk("desc_nwr", r_nwr, 16);
        chk("desc_first_data", r_first_data, 15);
        chk("desc_last_data", r_last_data, 0);
        chk("desc_done_c", r_done_c, 17);

        // Constant A5; fill_value and mode disturbed mid-fill
        @(posedge clk); #1;
        kick(0, 2'b10, 8'hA5, 1'b0);
        run_fill(0, 0, 300, 50, 0, 0, 1'b0, 0);
        chk("const_nwr", r_nwr, 256);
        chk("const_bad", r_bad_const, 0);
        chk("const_done_c", r_done_c, 257);

        // Grant pattern 1,0,0 repeating
        @(posedge clk); #1;
        kick(0, 2'b00, 8'h00, 1'b0);
        run_fill(0, 1, 900, 0, 0, 0, 1'b0, 0);
        chk("grant_nwr", r_nwr, 256);
        chk("grant_stalls", r_stalls, 510);
        chk("grant_done_c", r_done_c, 767);
        chk("grant_done_vs_stalls", r_done_c, 257 + r_stalls);

        // Abort at i=100, then a fresh fill (mode 11 behaves as identity)
        @(posedge clk); #1;
        kick(0, 2'b00, 8'h00, 1'b0);
        run_fill(0, 0, 150, 0, 101, 0, 1'b0, 0);
        chk("abort_nwr", r_nwr, 100);
        chk("abort_done_c", r_done_c, 0);
        @(posedge clk); #1;
        kick(0, 2'b11, 8'h3C, 1'b0);
        run_fill(0, 0, 300, 0, 0, 0, 1'b0, 0);
        chk("restart_first_addr", r_first_addr, 0);
        chk("restart_last_data", r_last_data, 255);
        chk("restart_done_c", r_done_c, 257);

        // Reset mid-fill at i=50 (descending)
        @(posedge clk); #1;
        kick(0, 2'b01, 8'h00, 1'b0);
        run_fill(0, 0, 80, 0, 0, 51, 1'b0, 50);
        chk("rst_probe_addr", r_probe_addr, 49);
        chk("rst_probe_data", r_probe_data, 206);
        chk("rst_outputs", r_rst_or, 0);
        chk("rst_nwr", r_nwr, 50);
        chk("rst_done_c", r_done_c, 0);

        // start held high across DONE
        @(posedge clk); #1;
        kick(0, 2'b00, 8'h00, 1'b1);
        run_fill(0, 0, 300, 0, 0, 0, 1'b1, 0);
        chk("hold_done_c", r_done_c, 257);
        chk("hold_busy_after", r_busy_after, 0);
        chk("hold_restart_c", r_wad_c, 259);
        chk("hold_restart_addr", r_wad_addr, 0);
        k = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (done_o[0]) begin
                k = n;
                break;
            end
        end
        chk("hold_second_done", k, 256);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
